// File: rtl/axi4lite_mem_responder_if.sv
// axi4lite_mem_responder_if: AXI4-Lite bus between an initiator and the memory responder
interface axi4lite_mem_responder_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   S_AXI_AWADDR;
   logic [2:0]          S_AXI_AWPROT;
   logic                S_AXI_AWVALID;
   logic                S_AXI_AWREADY;
   logic [DATA_W-1:0]   S_AXI_WDATA;
   logic [DATA_W/8-1:0] S_AXI_WSTRB;
   logic                S_AXI_WVALID;
   logic                S_AXI_WREADY;
   logic [1:0]          S_AXI_BRESP;
   logic                S_AXI_BVALID;
   logic                S_AXI_BREADY;
   logic [ADDR_W-1:0]   S_AXI_ARADDR;
   logic [2:0]          S_AXI_ARPROT;
   logic                S_AXI_ARVALID;
   logic                S_AXI_ARREADY;
   logic [DATA_W-1:0]   S_AXI_RDATA;
   logic [1:0]          S_AXI_RRESP;
   logic                S_AXI_RVALID;
   logic                S_AXI_RREADY;
   modport master (
      output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
             S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
      input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
             S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );
   modport slave (
      input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
             S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID, S_AXI_RREADY,
      output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
             S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
   );
endinterface

// File: rtl/axi4lite_mem_responder.sv
// axi4lite_mem_responder: AXI4-Lite slave over a byte-strobed word array; out-of-range
// accesses return SLVERR and raise a sticky ERROR flag.
module axi4lite_mem_responder #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 8,
   parameter int C_MEM_WORDS = 16
) (
   input  logic                     ACLK,
   input  logic                     ARESET,
   axi4lite_mem_responder_if.slave  s_axi,
   output logic                     ERROR
);
   localparam int IW = C_S_AXI_ADDR_WIDTH - 2;
   localparam int MW = C_MEM_WORDS > 1 ? $clog2(C_MEM_WORDS) : 1;
   localparam int NB = C_S_AXI_DATA_WIDTH / 8;
   localparam logic [1:0] OKAY = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   logic [C_S_AXI_DATA_WIDTH-1:0] mem_q [C_MEM_WORDS];
   logic                          aw_held_q, w_held_q, bvalid_q, rvalid_q, error_q;
   logic                          awready_q, wready_q, arready_q;
   logic                          aw_held_d, w_held_d, bvalid_d, rvalid_d;
   logic [IW-1:0]                 awidx_q, awidx, aridx;
   logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, rdata_q;
   logic [NB-1:0]                 wstrb_q;
   logic [1:0]                    bresp_q, rresp_q;
   logic                          aw_hs, w_hs, ar_hs, b_hs, r_hs, commit, aw_ok, ar_ok;
   logic                          unused;
   assign unused = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};
   always_comb begin
      awidx     = s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
      aridx     = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
      aw_hs     = s_axi.S_AXI_AWVALID && awready_q;
      w_hs      = s_axi.S_AXI_WVALID && wready_q;
      ar_hs     = s_axi.S_AXI_ARVALID && arready_q;
      b_hs      = bvalid_q && s_axi.S_AXI_BREADY;
      r_hs      = rvalid_q && s_axi.S_AXI_RREADY;
      commit    = aw_held_q && w_held_q && !bvalid_q;
      aw_ok     = 32'(awidx_q) < 32'(C_MEM_WORDS);
      ar_ok     = 32'(aridx) < 32'(C_MEM_WORDS);
      aw_held_d = b_hs ? 1'b0 : aw_held_q || aw_hs;
      w_held_d  = b_hs ? 1'b0 : w_held_q || w_hs;
      bvalid_d  = b_hs ? 1'b0 : bvalid_q || commit;
      rvalid_d  = r_hs ? 1'b0 : rvalid_q || ar_hs;
   end
   // Ready flags are registered copies of the next-state hold/valid bits.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         awready_q <= 1'b1;
         wready_q  <= 1'b1;
         arready_q <= 1'b1;
         bresp_q   <= OKAY;
         rresp_q   <= OKAY;
         rdata_q   <= '0;
         error_q   <= 1'b0;
      end else begin
         aw_held_q <= aw_held_d;
         w_held_q  <= w_held_d;
         bvalid_q  <= bvalid_d;
         rvalid_q  <= rvalid_d;
         awready_q <= !aw_held_d && !bvalid_d;
         wready_q  <= !w_held_d && !bvalid_d;
         arready_q <= !rvalid_d;
         if (commit) bresp_q <= aw_ok ? OKAY : SLVERR;
         if (ar_hs) begin
            rdata_q <= ar_ok ? mem_q[aridx[MW-1:0]] : '0;
            rresp_q <= ar_ok ? OKAY : SLVERR;
         end
         error_q <= error_q || (commit && !aw_ok) || (ar_hs && !ar_ok);
      end
   end
   // Datapath and array carry no reset; a read on the commit edge sees the old word.
   always_ff @(posedge ACLK) begin
      if (aw_hs) awidx_q <= awidx;
      if (w_hs) begin
         wdata_q <= s_axi.S_AXI_WDATA;
         wstrb_q <= s_axi.S_AXI_WSTRB;
      end
      if (!ARESET && commit && aw_ok)
         for (int k = 0; k < NB; k++)
            if (wstrb_q[k]) mem_q[awidx_q[MW-1:0]][8*k +: 8] <= wdata_q[8*k +: 8];
   end
   assign s_axi.S_AXI_AWREADY = awready_q;
   assign s_axi.S_AXI_WREADY  = wready_q;
   assign s_axi.S_AXI_BVALID  = bvalid_q;
   assign s_axi.S_AXI_BRESP   = bresp_q;
   assign s_axi.S_AXI_ARREADY = arready_q;
   assign s_axi.S_AXI_RVALID  = rvalid_q;
   assign s_axi.S_AXI_RDATA   = rdata_q;
   assign s_axi.S_AXI_RRESP   = rresp_q;
   assign ERROR               = error_q;
endmodule

// File: tb/tb_axi4lite_mem_responder.sv
// tb_axi4lite_mem_responder: vector table, corner-case sequences and random traffic
// checked against an array model of the responder.
module tb_axi4lite_mem_responder;
   logic clk = 1'b0, arst;
   logic [7:0] awaddr, araddr;
   logic [31:0] wdata, rdata;
   logic [3:0] wstrb;
   logic awvalid, wvalid, bready, arvalid, rready;
   logic awready, wready, bvalid, arready, rvalid, error;
   logic [1:0] bresp, rresp;
   int errs = 0, checks = 0;
   logic [31:0] mm [64];
   logic merr;
   logic [31:0] rdv;
   logic [1:0] rsp;
   logic [7:0] ra;
   logic [31:0] rd_d;
   logic [3:0] rs;
   typedef struct {
      bit          is_wr;
      logic [7:0]  a;
      logic [31:0] d;
      logic [3:0]  s;
      logic [31:0] exp;
      logic [1:0]  resp;
   } vec_t;
   vec_t vt [15];
   axi4lite_mem_responder_if #(.ADDR_W(8), .DATA_W(32)) bus ();
   assign bus.S_AXI_AWADDR  = awaddr;
   assign bus.S_AXI_AWPROT  = 3'b000;
   assign bus.S_AXI_AWVALID = awvalid;
   assign bus.S_AXI_WDATA   = wdata;
   assign bus.S_AXI_WSTRB   = wstrb;
   assign bus.S_AXI_WVALID  = wvalid;
   assign bus.S_AXI_BREADY  = bready;
   assign bus.S_AXI_ARADDR  = araddr;
   assign bus.S_AXI_ARPROT  = 3'b000;
   assign bus.S_AXI_ARVALID = arvalid;
   assign bus.S_AXI_RREADY  = rready;
   assign awready = bus.S_AXI_AWREADY;
   assign wready  = bus.S_AXI_WREADY;
   assign bvalid  = bus.S_AXI_BVALID;
   assign bresp   = bus.S_AXI_BRESP;
   assign arready = bus.S_AXI_ARREADY;
   assign rvalid  = bus.S_AXI_RVALID;
   assign rdata   = bus.S_AXI_RDATA;
   assign rresp   = bus.S_AXI_RRESP;
   axi4lite_mem_responder #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8), .C_MEM_WORDS(16)) dut (
      .ACLK(clk), .ARESET(arst), .s_axi(bus), .ERROR(error)
   );
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end
   task automatic chk(input string n, input logic [39:0] act, input logic [39:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h required %0h", n, act, exp);
      end
   endtask
   // Model: 16 words of storage, everything at word index >= 16 is an error.
   function automatic logic [1:0] m_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
      if (a[7:2] >= 6'd16) begin
         merr = 1'b1;
         return 2'b10;
      end
      for (int k = 0; k < 4; k++) if (s[k]) mm[a[7:2]][8*k +: 8] = d[8*k +: 8];
      return 2'b00;
   endfunction
   function automatic logic [33:0] m_rd(input logic [7:0] a);
      if (a[7:2] >= 6'd16) begin
         merr = 1'b1;
         return {2'b10, 32'h0};
      end
      return {2'b00, mm[a[7:2]]};
   endfunction
   // Called at a negedge; returns at a negedge after the B handshake.
   task automatic do_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int da, input int dw, output logic [1:0] r);
      bit ad = 0, wd = 0;
      int n = 0;
      bready = 1'b1; awaddr = a; wdata = d; wstrb = s;
      while (!(ad && wd) && n < 30) begin
         awvalid = !ad && n >= da;
         wvalid  = !wd && n >= dw;
         if (awvalid && awready) ad = 1;
         if (wvalid && wready) wd = 1;
         @(negedge clk);
         n++;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      chk("wr_handshakes", {ad, wd}, 2'b11);
      chk("wr_held_not_ready", {awready, wready, bvalid}, 3'b000);
      @(negedge clk);
      chk("wr_bvalid_latency", bvalid, 1'b1);
      r = bresp;
      @(negedge clk);
      chk("wr_bvalid_clear", bvalid, 1'b0);
   endtask
   task automatic do_rd(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
      int n = 0;
      arvalid = 1'b1; araddr = a; rready = 1'b1;
      while (!arready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rd_arready_wait", n < 20, 1'b1);
      @(negedge clk);
      arvalid = 1'b0;
      chk("rd_rvalid_latency", rvalid, 1'b1);
      d = rdata; r = rresp;
      @(negedge clk);
      chk("rd_rvalid_clear", rvalid, 1'b0);
   endtask
   initial begin
      arst = 1'b1; awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
      awaddr = 0; araddr = 0; wdata = 0; wstrb = 0; merr = 0;
      for (int i = 0; i < 64; i++) mm[i] = 32'h0;
      vt[0]  = '{1'b1, 8'h00, 32'h1,        4'hF, 32'h0,        2'b00};
      vt[1]  = '{1'b1, 8'h04, 32'h2,        4'hF, 32'h0,        2'b00};
      vt[2]  = '{1'b1, 8'h08, 32'h3,        4'hF, 32'h0,        2'b00};
      vt[3]  = '{1'b1, 8'h0C, 32'h4,        4'hF, 32'h0,        2'b00};
      vt[4]  = '{1'b0, 8'h00, 32'h0,        4'h0, 32'h1,        2'b00};
      vt[5]  = '{1'b0, 8'h04, 32'h0,        4'h0, 32'h2,        2'b00};
      vt[6]  = '{1'b0, 8'h08, 32'h0,        4'h0, 32'h3,        2'b00};
      vt[7]  = '{1'b0, 8'h0C, 32'h0,        4'h0, 32'h4,        2'b00};
      vt[8]  = '{1'b1, 8'h14, 32'hFFFFFFFF, 4'hF, 32'h0,        2'b00};
      vt[9]  = '{1'b1, 8'h14, 32'h00000000, 4'h5, 32'h0,        2'b00};
      vt[10] = '{1'b0, 8'h14, 32'h0,        4'h0, 32'hFF00FF00, 2'b00};
      vt[11] = '{1'b1, 8'h1B, 32'h12345678, 4'hF, 32'h0,        2'b00};
      vt[12] = '{1'b0, 8'h18, 32'h0,        4'h0, 32'h12345678, 2'b00};
      vt[13] = '{1'b1, 8'h3C, 32'hAABBCCDD, 4'hA, 32'h0,        2'b00};
      vt[14] = '{1'b0, 8'h3D, 32'h0,        4'h0, 32'hAA00CC00, 2'b00};
      repeat (3) @(negedge clk);
      chk("rst_flags", {awready, wready, arready, bvalid, rvalid, error}, 6'b111000);
      chk("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
      arst = 1'b0;
      @(negedge clk);
      chk("idle_flags", {awready, wready, arready, bvalid, rvalid, error}, 6'b111000);
      for (int i = 0; i < 15; i++) begin
         if (vt[i].is_wr) begin
            do_wr(vt[i].a, vt[i].d, vt[i].s, 0, 0, rsp);
            void'(m_wr(vt[i].a, vt[i].d, vt[i].s));
            chk($sformatf("vec%0d_bresp", i), rsp, vt[i].resp);
         end else begin
            do_rd(vt[i].a, rdv, rsp);
            chk($sformatf("vec%0d_rdata", i), rdv, vt[i].exp);
            chk($sformatf("vec%0d_rresp", i), rsp, vt[i].resp);
         end
      end
      chk("vec_error_clear", error, 1'b0);
      do_wr(8'h10, 32'hDEADBEEF, 4'hF, 0, 3, rsp);
      void'(m_wr(8'h10, 32'hDEADBEEF, 4'hF));
      chk("skew_aw_first_bresp", rsp, 2'b00);
      do_rd(8'h10, rdv, rsp);
      chk("skew_aw_first_rdata", rdv, 32'hDEADBEEF);
      do_wr(8'h10, 32'hCAFEF00D, 4'hF, 3, 0, rsp);
      void'(m_wr(8'h10, 32'hCAFEF00D, 4'hF));
      chk("skew_w_first_bresp", rsp, 2'b00);
      do_rd(8'h10, rdv, rsp);
      chk("skew_w_first_rdata", rdv, 32'hCAFEF00D);
      // Backpressure: second write waits on the bus while B is stalled.
      bready = 1'b0; awaddr = 8'h24; wdata = 32'h11111111; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      chk("bp_ready_start", {awready, wready}, 2'b11);
      @(negedge clk);
      awaddr = 8'h28; wdata = 32'h22222222;
      chk("bp_held", {awready, wready, bvalid}, 3'b000);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp_stable%0d", i), {bvalid, bresp, awready, wready}, 5'b10000);
         @(negedge clk);
      end
      bready = 1'b1;
      @(negedge clk);
      chk("bp_released", {bvalid, awready, wready}, 3'b011);
      @(negedge clk);
      awvalid = 0; wvalid = 0;
      chk("bp_second_accepted", {bvalid, awready, wready}, 3'b000);
      @(negedge clk);
      chk("bp_second_commit", {bvalid, bresp}, 3'b100);
      @(negedge clk);
      chk("bp_second_bclear", bvalid, 1'b0);
      void'(m_wr(8'h24, 32'h11111111, 4'hF));
      void'(m_wr(8'h28, 32'h22222222, 4'hF));
      do_rd(8'h24, rdv, rsp);
      chk("bp_rd_first", rdv, 32'h11111111);
      do_rd(8'h28, rdv, rsp);
      chk("bp_rd_second", rdv, 32'h22222222);
      do_wr(8'h40, 32'h99999999, 4'hF, 0, 0, rsp);
      void'(m_wr(8'h40, 32'h99999999, 4'hF));
      chk("err_bresp", rsp, 2'b10);
      chk("err_flag", error, 1'b1);
      do_rd(8'h40, rdv, rsp);
      chk("err_rd", {rsp, rdv}, 34'h200000000);
      do_rd(8'h00, rdv, rsp);
      chk("err_array_unchanged", rdv, 32'h1);
      chk("err_flag_sticky", error, 1'b1);
      // Collision: AR capture lands on the write-commit edge.
      awaddr = 8'h00; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1; rready = 0;
      chk("col_ready", {awready, wready, arready}, 3'b111);
      @(negedge clk);
      awvalid = 0; wvalid = 0; arvalid = 1; araddr = 8'h00;
      @(negedge clk);
      arvalid = 0;
      chk("col_same_edge", {bvalid, rvalid}, 2'b11);
      chk("col_old_data", rdata, 32'h1);
      void'(m_wr(8'h00, 32'h55, 4'hF));
      rready = 1;
      @(negedge clk);
      chk("col_done", {bvalid, rvalid}, 2'b00);
      do_rd(8'h00, rdv, rsp);
      chk("col_new_data", rdv, 32'h55);
      for (int i = 0; i < 60; i++) begin
         ra = 8'($urandom_range(0, 79));
         if ($urandom_range(0, 1) == 1) begin
            rd_d = $urandom;
            rs = 4'($urandom_range(0, 15));
            do_wr(ra, rd_d, rs, $urandom_range(0, 2), $urandom_range(0, 2), rsp);
            chk($sformatf("rnd%0d_bresp", i), rsp, m_wr(ra, rd_d, rs));
         end else begin
            do_rd(ra, rdv, rsp);
            chk($sformatf("rnd%0d_read", i), {rsp, rdv}, m_rd(ra));
         end
         chk($sformatf("rnd%0d_error", i), error, merr);
      end
      // Reset with B and R pending: both are dropped, the committed write survives.
      awaddr = 8'h2C; wdata = 32'h5A5AA5A5; wstrb = 4'hF; awvalid = 1; wvalid = 1;
      araddr = 8'h30; arvalid = 1; bready = 0; rready = 0;
      @(negedge clk);
      awvalid = 0; wvalid = 0; arvalid = 0;
      @(negedge clk);
      chk("mid_pending", {bvalid, rvalid}, 2'b11);
      arst = 1'b1;
      @(negedge clk);
      arst = 1'b0;
      merr = 1'b0;
      void'(m_wr(8'h2C, 32'h5A5AA5A5, 4'hF));
      chk("mid_reset_state", {bvalid, rvalid, error, awready, wready, arready}, 6'b000111);
      bready = 1; rready = 1;
      @(negedge clk);
      chk("mid_still_idle", {bvalid, rvalid}, 2'b00);
      do_rd(8'h2C, rdv, rsp);
      chk("mid_committed_kept", {rsp, rdv}, m_rd(8'h2C));
      chk("mid_error_clear", error, merr);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
